// File: rtl/dual_port_mem_responder.sv
// dual_port_mem_responder: two-port req/gnt/rvalid responder over one shared word RAM
// with round-robin arbitration, 1-cycle read latency and exported flag/result registers.
module dual_port_mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] FLAG_ADDR   = 32'h0000_FFF8,
    parameter logic [31:0] RESULT_ADDR = 32'h0000_FFFC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        p0_req_i,
    output logic        p0_gnt_o,
    output logic        p0_rvalid_o,
    input  logic [31:0] p0_addr_i,
    input  logic        p0_we_i,
    input  logic [3:0]  p0_be_i,
    input  logic [31:0] p0_wdata_i,
    output logic [31:0] p0_rdata_o,
    output logic        p0_err_o,
    input  logic        p1_req_i,
    output logic        p1_gnt_o,
    output logic        p1_rvalid_o,
    input  logic [31:0] p1_addr_i,
    input  logic        p1_we_i,
    input  logic [3:0]  p1_be_i,
    input  logic [31:0] p1_wdata_i,
    output logic [31:0] p1_rdata_o,
    output logic        p1_err_o,
    output logic [31:0] mem_flag_o,
    output logic [31:0] mem_result_o
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [29:0] BASE_W = BASE_ADDR[31:2];
    localparam logic [29:0] FLAG_W = FLAG_ADDR[31:2];
    localparam logic [29:0] RESULT_W = RESULT_ADDR[31:2];

    logic [31:0] ram_q [DEPTH];
    logic        last_grant_q, last_grant_d;
    logic [31:0] flag_q, flag_d, result_q, result_d;
    logic        p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
    logic        p0_err_q, p0_err_d, p1_err_q, p1_err_d;
    logic [31:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic        gnt0, gnt1, acc, sel, we, is_flag, is_res, in_ram, oor, ram_we;
    logic [31:0] a, wd, wmask, rd_val, rsp;
    logic [3:0]  be;
    logic [29:0] wa, woff;
    logic [IW-1:0] idx;

    // At most one port is granted per cycle, so a single muxed access path serves both.
    always_comb begin
        gnt0 = p0_req_i & (~p1_req_i | last_grant_q);
        gnt1 = p1_req_i & (~p0_req_i | ~last_grant_q);
        acc = gnt0 | gnt1;
        sel = gnt1;
        a = sel ? p1_addr_i : p0_addr_i;
        we = sel ? p1_we_i : p0_we_i;
        be = sel ? p1_be_i : p0_be_i;
        wd = sel ? p1_wdata_i : p0_wdata_i;
        wa = a[31:2];
        woff = wa - BASE_W;
        is_flag = wa == FLAG_W;
        is_res = wa == RESULT_W;
        in_ram = !is_flag && !is_res && wa >= BASE_W && woff < DEPTH_W;
        oor = !(is_flag || is_res || in_ram);
        idx = woff[IW-1:0];
        wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        rd_val = is_flag ? flag_q : is_res ? result_q : in_ram ? ram_q[idx] : 32'h0;
        rsp = we ? 32'h0 : rd_val;
        ram_we = acc && we && in_ram;
        flag_d = (acc && we && is_flag) ? (flag_q & ~wmask) | (wd & wmask) : flag_q;
        result_d = (acc && we && is_res) ? (result_q & ~wmask) | (wd & wmask) : result_q;
        last_grant_d = acc ? sel : last_grant_q;
        p0_rvalid_d = gnt0;
        p0_rdata_d = gnt0 ? rsp : p0_rdata_q;
        p0_err_d = gnt0 ? oor : p0_err_q;
        p1_rvalid_d = gnt1;
        p1_rdata_d = gnt1 ? rsp : p1_rdata_q;
        p1_err_d = gnt1 ? oor : p1_err_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= 1'b1;
            flag_q <= '0;
            result_q <= '0;
            p0_rvalid_q <= 1'b0;
            p0_rdata_q <= '0;
            p0_err_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p1_rdata_q <= '0;
            p1_err_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            flag_q <= flag_d;
            result_q <= result_d;
            p0_rvalid_q <= p0_rvalid_d;
            p0_rdata_q <= p0_rdata_d;
            p0_err_q <= p0_err_d;
            p1_rvalid_q <= p1_rvalid_d;
            p1_rdata_q <= p1_rdata_d;
            p1_err_q <= p1_err_d;
        end
    end

    // RAM contents survive reset; reset only blocks a write landing on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (!rst_i && ram_we)
            for (int i = 0; i < 4; i++)
                if (be[i]) ram_q[idx][8*i +: 8] <= wd[8*i +: 8];
    end

    assign p0_gnt_o = gnt0;
    assign p1_gnt_o = gnt1;
    assign p0_rvalid_o = p0_rvalid_q;
    assign p0_rdata_o = p0_rdata_q;
    assign p0_err_o = p0_err_q;
    assign p1_rvalid_o = p1_rvalid_q;
    assign p1_rdata_o = p1_rdata_q;
    assign p1_err_o = p1_err_q;
    assign mem_flag_o = flag_q;
    assign mem_result_o = result_q;
endmodule

// File: tb/tb_dual_port_mem_responder.sv
// tb_dual_port_mem_responder: directed checks of grants, responses, decode, registers and reset.
module tb_dual_port_mem_responder;
    logic        clk_i = 1'b0, rst_i;
    logic        p0_req_i, p0_gnt_o, p0_rvalid_o, p0_we_i, p0_err_o;
    logic        p1_req_i, p1_gnt_o, p1_rvalid_o, p1_we_i, p1_err_o;
    logic [31:0] p0_addr_i, p0_wdata_i, p0_rdata_o, p1_addr_i, p1_wdata_i, p1_rdata_o;
    logic [3:0]  p0_be_i, p1_be_i;
    logic [31:0] mem_flag_o, mem_result_o;
    int checks = 0, errors = 0;

    dual_port_mem_responder dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_req_i(p0_req_i), .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o),
        .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i), .p0_be_i(p0_be_i),
        .p0_wdata_i(p0_wdata_i), .p0_rdata_o(p0_rdata_o), .p0_err_o(p0_err_o),
        .p1_req_i(p1_req_i), .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o),
        .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i), .p1_be_i(p1_be_i),
        .p1_wdata_i(p1_wdata_i), .p1_rdata_o(p1_rdata_o), .p1_err_o(p1_err_o),
        .mem_flag_o(mem_flag_o), .mem_result_o(mem_result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        p0_req_i = 0; p0_we_i = 0; p0_addr_i = 0; p0_be_i = 0; p0_wdata_i = 0;
        p1_req_i = 0; p1_we_i = 0; p1_addr_i = 0; p1_be_i = 0; p1_wdata_i = 0;
    endtask

    task automatic put(input int p, input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        if (p == 0) begin
            p0_req_i = 1; p0_we_i = we; p0_addr_i = a; p0_be_i = be; p0_wdata_i = wd;
        end else begin
            p1_req_i = 1; p1_we_i = we; p1_addr_i = a; p1_be_i = be; p1_wdata_i = wd;
        end
    endtask

    task automatic rsp(input int p, input string tag, input logic [31:0] d, input logic e);
        chk({tag, " rvalid"}, (p == 0) ? p0_rvalid_o : p1_rvalid_o, 1);
        chk({tag, " rdata"}, (p == 0) ? p0_rdata_o : p1_rdata_o, d);
        chk({tag, " err"}, (p == 0) ? p0_err_o : p1_err_o, e);
    endtask

    initial begin
        idle();
        rst_i = 1;
        #2;
        chk("rst rvalid0", p0_rvalid_o, 0);
        chk("rst rvalid1", p1_rvalid_o, 0);
        chk("rst rdata0", p0_rdata_o, 0);
        chk("rst err1", p1_err_o, 0);
        chk("rst flag", mem_flag_o, 0);
        chk("rst result", mem_result_o, 0);
        @(negedge clk_i); rst_i = 0;
        // full-word write then read on p0
        put(0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
        #1 chk("t1 gnt0", p0_gnt_o, 1); chk("t1 gnt1", p1_gnt_o, 0);
        @(negedge clk_i); rsp(0, "t1 wr", 0, 0);
        put(0, 0, 32'h10, 4'h0, 0);
        #1 chk("t1 rd gnt0", p0_gnt_o, 1);
        @(negedge clk_i); rsp(0, "t1 rd", 32'hDEADBEEF, 0);
        idle();
        @(negedge clk_i);
        chk("t1 rvalid drop", p0_rvalid_o, 0);
        chk("t1 rdata hold", p0_rdata_o, 32'hDEADBEEF);
        // byte-enabled write on p1
        put(1, 1, 32'h10, 4'b0011, 32'h00001234);
        #1 chk("t2 gnt1", p1_gnt_o, 1); chk("t2 gnt0", p0_gnt_o, 0);
        @(negedge clk_i); rsp(1, "t2 wr", 0, 0);
        put(1, 0, 32'h10, 4'h0, 0);
        @(negedge clk_i); rsp(1, "t2 rd", 32'hDEAD1234, 0);
        idle();
        put(0, 1, 32'h20, 4'hF, 32'hCAFEF00D);
        @(negedge clk_i); idle(); put(1, 0, 32'h20, 4'h0, 0);
        @(negedge clk_i); rsp(1, "t2 raw", 32'hCAFEF00D, 0);
        idle();
        // out-of-range read/write, last RAM word
        put(0, 0, 32'h1000, 4'h0, 0);
        #1 chk("t4 oor gnt0", p0_gnt_o, 1);
        @(negedge clk_i); rsp(0, "t4 oor rd", 0, 1);
        put(0, 1, 32'h1010, 4'hF, 32'hFFFFFFFF);
        @(negedge clk_i); rsp(0, "t4 oor wr", 0, 1);
        put(0, 1, 32'hFFC, 4'hF, 32'h600DF00D);
        @(negedge clk_i); rsp(0, "t4 last wr", 0, 0);
        put(0, 0, 32'h10, 4'h0, 0);
        @(negedge clk_i); rsp(0, "t4 ram unchanged", 32'hDEAD1234, 0);
        put(0, 0, 32'hFFC, 4'h0, 0);
        @(negedge clk_i); rsp(0, "t4 last rd", 32'h600DF00D, 0);
        idle();
        // flag/result registers through p1
        put(1, 1, 32'hFFF8, 4'hF, 32'h1);
        #1 chk("t5 flag pre", mem_flag_o, 0);
        @(negedge clk_i); chk("t5 flag", mem_flag_o, 32'h1); rsp(1, "t5 flag wr", 0, 0);
        put(1, 1, 32'hFFFC, 4'hF, 32'h2A);
        #1 chk("t5 result pre", mem_result_o, 0);
        @(negedge clk_i); chk("t5 result", mem_result_o, 32'h2A);
        put(1, 0, 32'hFFF8, 4'h0, 0);
        @(negedge clk_i); rsp(1, "t5 flag rd", 32'h1, 0);
        put(1, 0, 32'hFFFC, 4'h0, 0);
        @(negedge clk_i); rsp(1, "t5 result rd", 32'h2A, 0);
        idle();
        // reset in the cycle after a p0 read grant, with a p1 write pending
        put(0, 0, 32'h10, 4'h0, 0);
        @(negedge clk_i); chk("t6 rvalid0 pre", p0_rvalid_o, 1);
        idle(); put(1, 1, 32'h10, 4'hF, 32'h55555555);
        rst_i = 1;
        #1 chk("t6 rvalid0", p0_rvalid_o, 0);
        chk("t6 flag", mem_flag_o, 0);
        chk("t6 result", mem_result_o, 0);
        chk("t6 rdata0", p0_rdata_o, 0);
        @(negedge clk_i); rst_i = 0; idle();
        // conflicts from reset: p0, p1, p0, p1
        put(0, 0, 32'h10, 4'h0, 0);
        put(1, 0, 32'h10, 4'h0, 0);
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("t3 gnt0 c%0d", k), p0_gnt_o, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("t3 gnt1 c%0d", k), p1_gnt_o, (k % 2 == 1) ? 1 : 0);
            @(negedge clk_i);
            chk($sformatf("t3 rvalid0 c%0d", k), p0_rvalid_o, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("t3 rvalid1 c%0d", k), p1_rvalid_o, (k % 2 == 1) ? 1 : 0);
            chk($sformatf("t3 rdata c%0d", k), (k % 2 == 0) ? p0_rdata_o : p1_rdata_o, 32'hDEAD1234);
        end
        idle();
        @(negedge clk_i);
        chk("t3 rvalid0 end", p0_rvalid_o, 0);
        chk("t3 rvalid1 end", p1_rvalid_o, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
